// File: rtl/exec_unit_mc_if.sv
// Bus bundle for the execute-stage unit: operands, operation selects,
// multiply handshake and results. The pipeline side uses the master modport,
// the execute unit uses the slave modport.
//
// Multiply handshake: mul_start is a single-cycle request that is accepted
// only when busy=0. Once accepted, busy stays high until the product is
// written to Hi/Lo. done pulses for exactly one cycle as busy falls. A
// mul_start seen while busy=1 is dropped and not queued. stall tells the
// pipeline to hold any instruction that touches Hi/Lo while busy=1.
interface exec_unit_mc_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
);
    logic [2:0]       operation;
    logic [1:0]       sht_op;
    logic [1:0]       out_sel;
    logic [WIDTH-1:0] dataA;
    logic [WIDTH-1:0] dataB;
    logic [SHW-1:0]   shamt;
    logic             mul_start;
    logic             mul_signed;
    logic [1:0]       hilo_wr;
    logic [WIDTH-1:0] Output;
    logic             Zero;
    logic             Ovf;
    logic             busy;
    logic             done;
    logic             stall;
    // Multiplier FSM state, exported for observation (0 idle, 1 run, 2 fin)
    logic [1:0]       mul_state;

    modport master (
        output operation, sht_op, out_sel, dataA, dataB, shamt,
               mul_start, mul_signed, hilo_wr,
        input  Output, Zero, Ovf, busy, done, stall, mul_state
    );

    modport slave (
        input  operation, sht_op, out_sel, dataA, dataB, shamt,
               mul_start, mul_signed, hilo_wr,
        output Output, Zero, Ovf, busy, done, stall, mul_state
    );
endinterface

// File: rtl/exec_unit_mc.sv
// Execute-stage unit: a combinational ALU and barrel shifter, an iterative
// shift-add multiplier for signed and unsigned operands, and the
// architectural Hi/Lo registers.
// WIDTH must be a power of two and at least 4. SHW must equal log2(WIDTH).
// CW must be at least log2(WIDTH)+1 so that the counter can hold WIDTH.
module exec_unit_mc #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5,
    parameter int CW    = 6
) (
    input  logic           clk,
    input  logic           rst,
    exec_unit_mc_if.slave  bus
);
    localparam int MSB = WIDTH - 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } mul_state_t;

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SHW-1:0]   sh;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             slt_bit;
    logic             add_ovf;
    logic             sub_ovf;
    logic [WIDTH-1:0] alu_result;
    logic             alu_ovf;
    logic [WIDTH-1:0] shift_result;
    logic [WIDTH-1:0] out_mux;

    mul_state_t         state;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               neg;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] prod_final;

    assign a  = bus.dataA;
    assign b  = bus.dataB;
    assign sh = bus.shamt;

    // ALU datapath: both sums are always formed so the overflow terms stay simple
    always_comb begin
        sum     = a + b;
        diff    = a - b;
        slt_bit = ($signed(a) < $signed(b));
        // ADD overflows when like-signed operands give a result of the other sign
        add_ovf = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
        // SUB overflows when unlike-signed operands give a result whose sign differs from A
        sub_ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
        alu_result = '0;
        alu_ovf    = 1'b0;
        case (bus.operation)
            OP_AND: alu_result = a & b;
            OP_OR:  alu_result = a | b;
            OP_ADD: begin
                alu_result = sum;
                alu_ovf    = add_ovf;
            end
            OP_SUB: begin
                alu_result = diff;
                alu_ovf    = sub_ovf;
            end
            OP_SLT: alu_result = {{(WIDTH-1){1'b0}}, slt_bit};
            default: begin
                alu_result = '0;
                alu_ovf    = 1'b0;
            end
        endcase
    end

    // Barrel shifter on dataB; SRA replicates the sign bit
    always_comb begin
        shift_result = b;
        case (bus.sht_op)
            2'b00:   shift_result = b << sh;
            2'b01:   shift_result = b >> sh;
            2'b10:   shift_result = $signed(b) >>> sh;
            default: shift_result = b;
        endcase
    end

    // Result select; Hi/Lo are read straight from the architectural registers
    always_comb begin
        out_mux = alu_result;
        case (bus.out_sel)
            2'b00:   out_mux = alu_result;
            2'b01:   out_mux = hi;
            2'b10:   out_mux = lo;
            default: out_mux = shift_result;
        endcase
    end

    // Operand magnitudes and the per-iteration / final product terms.
    // The most-negative value negates to itself, which read as unsigned is
    // exactly its magnitude, so no special case is needed.
    always_comb begin
        a_neg      = bus.mul_signed & a[MSB];
        b_neg      = bus.mul_signed & b[MSB];
        a_mag      = a_neg ? -a : a;
        b_mag      = b_neg ? -b : b;
        acc_next   = mplier[0] ? (acc + mcand) : acc;
        prod_final = neg ? -acc : acc;
    end

    // Multiplier FSM and Hi/Lo registers. Direct Hi/Lo writes are only taken
    // while idle; a write and a start in the same idle cycle both happen, and
    // the product later overwrites Hi/Lo.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.hilo_wr[1]) hi <= a;
                    if (bus.hilo_wr[0]) lo <= a;
                    if (bus.mul_start) begin
                        mcand  <= {{WIDTH{1'b0}}, a_mag};
                        mplier <= b_mag;
                        neg    <= a_neg ^ b_neg;
                        acc    <= '0;
                        cnt    <= CNT_INIT;
                        busy_q <= 1'b1;
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) state <= S_FIN;
                end
                S_FIN: begin
                    {hi, lo} <= prod_final;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.Output    = out_mux;
    assign bus.Zero      = (alu_result == '0);
    assign bus.Ovf       = alu_ovf;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.mul_state = state;
    // Hold any instruction that reads or writes Hi/Lo, or starts a multiply, while one is in flight
    assign bus.stall     = busy_q & ((bus.out_sel == 2'b01) | (bus.out_sel == 2'b10) |
                                     (|bus.hilo_wr) | bus.mul_start);
endmodule

// File: tb/tb_exec_unit_mc.sv
// Bench for exec_unit_mc: a cycle-level reference model derived from the
// unit's arithmetic rules, a per-cycle compare process, and directed vectors
// with hand-computed literal results.
module tb_exec_unit_mc;
    localparam int W = 32;
    localparam longint SMAX = (longint'(1) << (W-1)) - 1;
    localparam longint SMIN = -(longint'(1) << (W-1));

    int total = 0;
    int bad   = 0;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    exec_unit_mc_if #(.WIDTH(W), .SHW(5)) bus();

    exec_unit_mc #(.WIDTH(W), .SHW(5), .CW(6)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    logic [2*W-1:0] exp_q[$];   // products in flight, oldest first
    int             m_left;
    logic           m_busy;
    logic           m_done;
    logic [W-1:0]   m_hi;
    logic [W-1:0]   m_lo;

    function automatic logic [2*W-1:0] full_product(input logic sgn, input logic [W-1:0] a,
                                                    input logic [W-1:0] b);
        logic [2*W-1:0] ea;
        logic [2*W-1:0] eb;
        ea = sgn ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
        eb = sgn ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
        return ea * eb;
    endfunction

    function automatic logic [W-1:0] exp_alu(input logic [2:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b111:  return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            default: return '0;
        endcase
    endfunction

    function automatic logic exp_ovf(input logic [2:0] op, input logic [W-1:0] a,
                                     input logic [W-1:0] b);
        longint s;
        if (op == 3'b010)      s = longint'($signed(a)) + longint'($signed(b));
        else if (op == 3'b110) s = longint'($signed(a)) - longint'($signed(b));
        else return 1'b0;
        return (s > SMAX) || (s < SMIN);
    endfunction

    function automatic logic [W-1:0] exp_shift(input logic [1:0] op, input logic [W-1:0] b,
                                               input logic [4:0] n);
        logic signed [W-1:0] sb;
        sb = b;
        case (op)
            2'b00:   return b << n;
            2'b01:   return b >> n;
            2'b10:   return sb >>> n;
            default: return b;
        endcase
    endfunction

    function automatic logic [W-1:0] exp_out();
        case (bus.out_sel)
            2'b00:   return exp_alu(bus.operation, bus.dataA, bus.dataB);
            2'b01:   return m_hi;
            2'b10:   return m_lo;
            default: return exp_shift(bus.sht_op, bus.dataB, bus.shamt);
        endcase
    endfunction

    // Model: an accepted start makes busy last WIDTH+1 edges, then Hi/Lo take the product
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            m_left <= 0;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_hi   <= exp_q[0][2*W-1:W];
                    m_lo   <= exp_q[0][W-1:0];
                    void'(exp_q.pop_front());
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                end
            end else begin
                if (bus.hilo_wr[1]) m_hi <= bus.dataA;
                if (bus.hilo_wr[0]) m_lo <= bus.dataA;
                if (bus.mul_start) begin
                    exp_q.push_back(full_product(bus.mul_signed, bus.dataA, bus.dataB));
                    m_left <= W + 1;
                    m_busy <= 1'b1;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle, compare all outputs against the model
    always @(negedge clk) begin
        chk("cyc_output", 64'(bus.Output), 64'(exp_out()));
        chk("cyc_zero", 64'(bus.Zero), 64'(exp_alu(bus.operation, bus.dataA, bus.dataB) == '0));
        chk("cyc_ovf", 64'(bus.Ovf), 64'(exp_ovf(bus.operation, bus.dataA, bus.dataB)));
        chk("cyc_busy", 64'(bus.busy), 64'(m_busy));
        chk("cyc_done", 64'(bus.done), 64'(m_done));
        chk("cyc_stall", 64'(bus.stall),
            64'(m_busy && (bus.out_sel == 2'b01 || bus.out_sel == 2'b10 ||
                           bus.hilo_wr != 2'b00 || bus.mul_start)));
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int busy_cycles, output logic seen);
        busy_cycles = 0;
        seen        = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            if (bus.busy) busy_cycles++;
        end
        chk("done_within_bound", 64'(seen), 64'd1);
    endtask

    task automatic run_mul(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                           output int busy_cycles, output logic seen);
        step();
        bus.dataA      = a;
        bus.dataB      = b;
        bus.mul_signed = sgn;
        bus.mul_start  = 1'b1;
        step();
        bus.mul_start  = 1'b0;
        wait_done(busy_cycles, seen);
    endtask

    task automatic set_alu(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        step();
        bus.out_sel   = 2'b00;
        bus.operation = op;
        bus.dataA     = a;
        bus.dataB     = b;
        @(negedge clk);
    endtask

    task automatic set_shift(input logic [1:0] op, input logic [W-1:0] b, input logic [4:0] n);
        step();
        bus.out_sel = 2'b11;
        bus.sht_op  = op;
        bus.dataB   = b;
        bus.shamt   = n;
        @(negedge clk);
    endtask

    // ---------------- directed stimulus ----------------
    int   nb;
    logic seen;
    int   done_cnt;

    initial begin
        bus.operation  = 3'b000;
        bus.sht_op     = 2'b00;
        bus.out_sel    = 2'b00;
        bus.dataA      = '0;
        bus.dataB      = '0;
        bus.shamt      = '0;
        bus.mul_start  = 1'b0;
        bus.mul_signed = 1'b0;
        bus.hilo_wr    = 2'b00;
        #1 rst_n = 1'b0;

        // Reset state
        step();
        bus.out_sel = 2'b01;
        @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_hi", 64'(bus.Output), 64'd0);
        step();
        bus.out_sel = 2'b10;
        @(negedge clk);
        chk("rst_lo", 64'(bus.Output), 64'd0);
        step();
        rst_n = 1'b1;

        // ALU
        set_alu(3'b010, 32'h7FFF_FFFF, 32'h0000_0001);
        chk("add_out", 64'(bus.Output), 64'h8000_0000);
        chk("add_ovf", 64'(bus.Ovf), 64'd1);
        chk("add_zero", 64'(bus.Zero), 64'd0);
        set_alu(3'b110, 32'd5, 32'd5);
        chk("sub_out", 64'(bus.Output), 64'd0);
        chk("sub_zero", 64'(bus.Zero), 64'd1);
        chk("sub_ovf", 64'(bus.Ovf), 64'd0);
        set_alu(3'b110, 32'h8000_0000, 32'd1);
        chk("sub_ovf_neg", 64'(bus.Ovf), 64'd1);
        set_alu(3'b111, 32'hFFFF_FFFF, 32'd1);
        chk("slt_true", 64'(bus.Output), 64'd1);
        set_alu(3'b111, 32'd1, 32'hFFFF_FFFF);
        chk("slt_false", 64'(bus.Output), 64'd0);
        set_alu(3'b000, 32'hF0F0_1234, 32'h0FF0_FF00);
        chk("and_out", 64'(bus.Output), 64'h00F0_1200);
        set_alu(3'b001, 32'hF0F0_1234, 32'h0FF0_FF00);
        chk("or_out", 64'(bus.Output), 64'hFFF0_FF34);
        set_alu(3'b011, 32'h1234_5678, 32'h1111_1111);
        chk("bad_op_out", 64'(bus.Output), 64'd0);
        chk("bad_op_ovf", 64'(bus.Ovf), 64'd0);

        // Shifter
        set_shift(2'b10, 32'h8000_0000, 5'd4);
        chk("sra", 64'(bus.Output), 64'hF800_0000);
        set_shift(2'b01, 32'h8000_0000, 5'd4);
        chk("srl", 64'(bus.Output), 64'h0800_0000);
        set_shift(2'b00, 32'h0000_0001, 5'd31);
        chk("sll", 64'(bus.Output), 64'h8000_0000);
        set_shift(2'b10, 32'h8765_4321, 5'd0);
        chk("sra_zero_amt", 64'(bus.Output), 64'h8765_4321);
        set_shift(2'b11, 32'hCAFE_F00D, 5'd7);
        chk("pass_b", 64'(bus.Output), 64'hCAFE_F00D);

        // MTHI / MTLO while idle
        step();
        bus.hilo_wr = 2'b11;
        bus.dataA   = 32'h1234_5678;
        step();
        bus.hilo_wr = 2'b00;
        bus.out_sel = 2'b01;
        @(negedge clk);
        chk("mthi", 64'(bus.Output), 64'h1234_5678);
        step();
        bus.out_sel = 2'b10;
        @(negedge clk);
        chk("mtlo", 64'(bus.Output), 64'h1234_5678);

        // MULTU max x max: 33 busy cycles, Hi read on the done cycle without stall
        step();
        bus.out_sel = 2'b01;
        run_mul(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, nb, seen);
        chk("multu_busy_cycles", 64'(nb), 64'd33);
        chk("multu_hi", 64'(bus.Output), 64'hFFFF_FFFE);
        chk("multu_done_stall", 64'(bus.stall), 64'd0);
        step();
        bus.out_sel = 2'b10;
        @(negedge clk);
        chk("multu_lo", 64'(bus.Output), 64'h0000_0001);

        // MULT -3 x 5
        step();
        bus.out_sel = 2'b01;
        run_mul(1'b1, 32'hFFFF_FFFD, 32'd5, nb, seen);
        chk("mult_neg_hi", 64'(bus.Output), 64'hFFFF_FFFF);
        step();
        bus.out_sel = 2'b10;
        @(negedge clk);
        chk("mult_neg_lo", 64'(bus.Output), 64'hFFFF_FFF1);

        // MULT most-negative squared
        step();
        bus.out_sel = 2'b01;
        run_mul(1'b1, 32'h8000_0000, 32'h8000_0000, nb, seen);
        chk("mult_min_hi", 64'(bus.Output), 64'h4000_0000);
        step();
        bus.out_sel = 2'b10;
        @(negedge clk);
        chk("mult_min_lo", 64'(bus.Output), 64'd0);

        // Interlock: restart and Hi write during busy are dropped
        step();
        bus.hilo_wr = 2'b10;
        bus.dataA   = 32'h0000_1111;
        step();
        bus.hilo_wr    = 2'b00;
        bus.out_sel    = 2'b01;
        bus.dataA      = 32'h0001_0000;
        bus.dataB      = 32'h0003_0000;
        bus.mul_signed = 1'b0;
        bus.mul_start  = 1'b1;
        step();
        bus.mul_start = 1'b0;
        @(negedge clk);
        chk("lock_stall_read", 64'(bus.stall), 64'd1);
        step();
        bus.dataA     = 32'hFFFF_FFFF;
        bus.dataB     = 32'hFFFF_FFFF;
        bus.mul_start = 1'b1;
        @(negedge clk);
        chk("lock_stall_start", 64'(bus.stall), 64'd1);
        step();
        bus.mul_start = 1'b0;
        bus.hilo_wr   = 2'b10;
        bus.dataA     = 32'h0000_DEAD;
        @(negedge clk);
        chk("lock_stall_wr", 64'(bus.stall), 64'd1);
        step();
        bus.hilo_wr = 2'b00;
        @(negedge clk);
        chk("lock_hi_unwritten", 64'(bus.Output), 64'h0000_1111);
        wait_done(nb, seen);
        chk("lock_busy_rest", 64'(nb), 64'd29);
        chk("lock_hi_product", 64'(bus.Output), 64'd3);
        step();
        bus.out_sel = 2'b10;
        @(negedge clk);
        chk("lock_lo_product", 64'(bus.Output), 64'd0);

        // Hi/Lo write and start in the same idle cycle
        step();
        bus.hilo_wr    = 2'b11;
        bus.dataA      = 32'h0000_AAAA;
        bus.dataB      = 32'd2;
        bus.mul_signed = 1'b0;
        bus.mul_start  = 1'b1;
        bus.out_sel    = 2'b01;
        step();
        bus.hilo_wr   = 2'b00;
        bus.mul_start = 1'b0;
        @(negedge clk);
        chk("both_hi_written", 64'(bus.Output), 64'h0000_AAAA);
        wait_done(nb, seen);
        chk("both_busy_rest", 64'(nb), 64'd32);
        chk("both_hi_product", 64'(bus.Output), 64'd0);
        step();
        bus.out_sel = 2'b10;
        @(negedge clk);
        chk("both_lo_product", 64'(bus.Output), 64'h0001_5554);

        // Reset mid-multiply
        step();
        bus.out_sel    = 2'b01;
        bus.dataA      = 32'hFFFF_FFFF;
        bus.dataB      = 32'hFFFF_FFFF;
        bus.mul_signed = 1'b0;
        bus.mul_start  = 1'b1;
        step();
        bus.mul_start = 1'b0;
        repeat (10) step();
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_hi", 64'(bus.Output), 64'd0);
        step();
        rst_n       = 1'b1;
        bus.out_sel = 2'b10;
        @(negedge clk);
        chk("abort_lo", 64'(bus.Output), 64'd0);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) done_cnt++;
        end
        chk("abort_no_done", 64'(done_cnt), 64'd0);

        // Multiply after abort completes normally
        step();
        bus.out_sel = 2'b10;
        run_mul(1'b1, 32'd6, 32'd7, nb, seen);
        chk("post_abort_cycles", 64'(nb), 64'd33);
        chk("post_abort_lo", 64'(bus.Output), 64'd42);
        step();
        bus.out_sel = 2'b01;
        @(negedge clk);
        chk("post_abort_hi", 64'(bus.Output), 64'd0);

        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
